shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request a shift operation; sampled only in IDLE.
REQ-004 The block SHALL have port op, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV; 110 and 111 are illegal.
REQ-005 The block SHALL have port shamt, input, 5 bits: immediate shift amount.
REQ-006 The block SHALL have port amt_var, input, 5 bits: variable shift amount, rs[4:0].
REQ-007 The block SHALL have port SHIFTER_control, output, 3 bits: shifter command; 000 hold, 001 load, 010 shift left, 011 shift right logical, 100 shift right arithmetic.
REQ-008 The block SHALL have port M_SHIFTER, output, 1 bit: shift-amount mux select; 0 selects shamt, 1 selects the variable amount.
REQ-009 The block SHALL have port M_ALUOut_control, output, 3 bits: ALUOut mux select; 010 selects the shifter, 000 otherwise.
REQ-010 The block SHALL have port alu_out_wr, output, 1 bit: ALUOut register write enable.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse when an illegal op is rejected.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, SHIFT, CAPTURE and DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-015 When start=1 in IDLE with a legal op, the block SHALL latch op and the effective amount and go to LOAD; the effective amount is amt_var for op 011–101 and shamt otherwise.
REQ-016 The transitions SHALL be LOAD->SHIFT->CAPTURE->DONE->IDLE.
REQ-017 In LOAD, SHIFTER_control SHALL be 001.
REQ-018 In SHIFT, SHIFTER_control SHALL be the latched direction code: SLL/SLLV 010, SRL/SRLV 011, SRA/SRAV 100.
REQ-019 In CAPTURE, SHIFTER_control SHALL be 000, M_ALUOut_control SHALL be 010 and alu_out_wr SHALL be 1.
REQ-020 In DONE, done SHALL be 1, and all other command outputs SHALL be 000/0.
REQ-021 M_SHIFTER SHALL equal the latched variable-amount flag from LOAD through CAPTURE, and SHALL be 0 in IDLE and DONE.
REQ-022 Latency: with start sampled at edge t, done SHALL be high in the cycle following edge t+3, and busy SHALL be high for exactly 4 cycles.
REQ-023 start while busy=1 SHALL be ignored; op, shamt and amt_var SHALL NOT be re-sampled.
REQ-024 start=1 with an illegal op in IDLE SHALL pulse err for one cycle and leave the state in IDLE, with no shifter command issued.
REQ-025 start=1 in the same cycle that DONE is active SHALL be ignored; a new request is accepted only once the state is IDLE.
REQ-026 All outputs SHALL be registered or decoded from state only, with no combinational path from start or op to any output.

Reset
REQ-027 While reset=0, the state SHALL be IDLE and every output SHALL be 0, including SHIFTER_control=000 and M_ALUOut_control=000.
REQ-028 An assertion of reset in any state SHALL abort the operation immediately, with no done and no alu_out_wr pulse.
REQ-029 After reset deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-030 The macro SHIFT_ZERO_SKIP_EN SHALL select zero-amount handling.
REQ-031 With SHIFT_ZERO_SKIP_EN defined and a latched effective amount of 0, the block SHALL go LOAD->CAPTURE, skipping SHIFT, so done occurs one cycle earlier and busy lasts 3 cycles.
REQ-032 Without SHIFT_ZERO_SKIP_EN, SHIFT SHALL always be visited regardless of amount.

Verification
REQ-033 The bench SHALL cover: op=000, shamt=4, start pulse -> SHIFTER_control sequence 001,010,000; alu_out_wr in cycle 3; done in cycle 4; M_SHIFTER=0 throughout.
REQ-034 The bench SHALL cover: op=101, amt_var=31 -> M_SHIFTER=1 from LOAD through CAPTURE; SHIFT code 100; busy for 4 cycles.
REQ-035 The bench SHALL cover: op=110 with start -> err=1 for 1 cycle; busy stays 0; SHIFTER_control stays 000.
REQ-036 The bench SHALL cover: start re-asserted with op=001 during SHIFT of a running SLL -> ignored; the SLL completes unchanged; a single done pulse.
REQ-037 The bench SHALL cover: reset driven low during CAPTURE -> all outputs 0 immediately; no done pulse; a new start is accepted normally after release.
REQ-038 The bench SHALL cover: op=001, shamt=0 -> with SHIFT_ZERO_SKIP_EN, SHIFTER_control sequence 001,000 and done in cycle 3; without it, sequence 001,011,000 and done in cycle 4.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: IDLE -> LOAD -> SHIFT -> CAPTURE -> DONE.
// Optional SHIFT_ZERO_SKIP_EN skips the SHIFT state when the latched amount is zero.
`timescale 1ns/1ps

module shift_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] shamt,
    input  logic [4:0] amt_var,
    output logic [2:0] SHIFTER_control,
    output logic       M_SHIFTER,
    output logic [2:0] M_ALUOut_control,
    output logic       alu_out_wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef SHIFT_ZERO_SKIP_EN
    localparam logic ZERO_SKIP_EN = 1'b1;
`else
    localparam logic ZERO_SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    function automatic logic op_legal(input logic [2:0] op_in);
        case (op_in)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_var(input logic [2:0] op_in);
        case (op_in)
            3'b011, 3'b100, 3'b101: op_is_var = 1'b1;
            default:                op_is_var = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] dir_code(input logic [2:0] op_in);
        case (op_in)
            3'b000, 3'b011: dir_code = 3'b010;
            3'b001, 3'b100: dir_code = 3'b011;
            3'b010, 3'b101: dir_code = 3'b100;
            default:        dir_code = 3'b000;
        endcase
    endfunction

    state_t     state_r, next_state_s;
    logic [2:0] dir_r, dir_n_s;
    logic [4:0] amt_r, amt_n_s;
    logic       var_r, var_n_s;
    logic       accept_s, reject_s;

    logic [2:0] ctrl_s, mux_s;
    logic       msh_s, wr_s, busy_s, done_s;
    logic [2:0] ctrl_r, mux_r;
    logic       msh_r, wr_r, busy_r, done_r, err_r;

    assign accept_s = (state_r == IDLE) && start && op_legal(op);
    assign reject_s = (state_r == IDLE) && start && !op_legal(op);

    // Operation latch: captured only when a legal request is accepted in IDLE
    always_comb begin
        dir_n_s = dir_r;
        amt_n_s = amt_r;
        var_n_s = var_r;
        if (accept_s) begin
            dir_n_s = dir_code(op);
            var_n_s = op_is_var(op);
            amt_n_s = op_is_var(op) ? amt_var : shamt;
        end else begin
            dir_n_s = dir_r;
            amt_n_s = amt_r;
            var_n_s = var_r;
        end
    end

    // Next-state sequencing
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (ZERO_SKIP_EN && (amt_r == 5'd0)) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            SHIFT:   next_state_s = CAPTURE;
            CAPTURE: next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Command decode for the upcoming state; registered below so outputs align with state
    always_comb begin
        ctrl_s = 3'b000;
        mux_s  = 3'b000;
        msh_s  = 1'b0;
        wr_s   = 1'b0;
        done_s = 1'b0;
        busy_s = (next_state_s != IDLE);
        case (next_state_s)
            LOAD: begin
                ctrl_s = 3'b001;
                msh_s  = var_n_s;
            end
            SHIFT: begin
                ctrl_s = dir_n_s;
                msh_s  = var_n_s;
            end
            CAPTURE: begin
                mux_s  = 3'b010;
                wr_s   = 1'b1;
                msh_s  = var_n_s;
            end
            DONE:    done_s = 1'b1;
            default: ctrl_s = 3'b000;
        endcase
    end

    // State and latched operation registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            dir_r   <= 3'b000;
            amt_r   <= 5'd0;
            var_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            dir_r   <= dir_n_s;
            amt_r   <= amt_n_s;
            var_r   <= var_n_s;
        end
    end

    // Output registers; reset clears them at once so an aborted op emits nothing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= 3'b000;
            mux_r  <= 3'b000;
            msh_r  <= 1'b0;
            wr_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            ctrl_r <= ctrl_s;
            mux_r  <= mux_s;
            msh_r  <= msh_s;
            wr_r   <= wr_s;
            busy_r <= busy_s;
            done_r <= done_s;
            err_r  <= reject_s;
        end
    end

    assign SHIFTER_control  = ctrl_r;
    assign M_SHIFTER        = msh_r;
    assign M_ALUOut_control = mux_r;
    assign alu_out_wr       = wr_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; expected per-cycle output vectors are queued
// by the stimulus and popped by a monitor whenever busy, done or err is presented.
`timescale 1ns/1ps

module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [4:0] shamt = 5'd0;
    logic [4:0] amt_var = 5'd0;
    logic [2:0] SHIFTER_control;
    logic       M_SHIFTER;
    logic [2:0] M_ALUOut_control;
    logic       alu_out_wr;
    logic       busy;
    logic       done;
    logic       err;

    logic [10:0] outv;
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    string       cur_test = "none";

`ifdef SHIFT_ZERO_SKIP_EN
    localparam logic SKIP = 1'b1;
`else
    localparam logic SKIP = 1'b0;
`endif

    shift_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .shamt            (shamt),
        .amt_var          (amt_var),
        .SHIFTER_control  (SHIFTER_control),
        .M_SHIFTER        (M_SHIFTER),
        .M_ALUOut_control (M_ALUOut_control),
        .alu_out_wr       (alu_out_wr),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    assign outv = {SHIFTER_control, M_SHIFTER, M_ALUOut_control, alu_out_wr, busy, done, err};

    function automatic logic [10:0] vec(input logic [2:0] c, input logic m, input logic [2:0] x,
                                        input logic w, input logic b, input logic d, input logic e);
        return {c, m, x, w, b, d, e};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ctrl/msh/mux/wr/busy/done/err=%b required %b", name, act, expv);
        end
    endtask

    // Expected LOAD, SHIFT (unless skipped), CAPTURE, DONE vectors for one accepted op
    task automatic push_op(input logic [2:0] dir, input logic vflag, input logic skip);
        exp_q.push_back(vec(3'b001, vflag, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
        if (!skip) exp_q.push_back(vec(dir, vflag, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'b000, vflag, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [4:0] sh, input logic [4:0] av,
                          input logic [2:0] dir, input logic vflag, input logic skip);
        cur_test = name;
        push_op(dir, vflag, skip);
        @(negedge clk);
        op = o; shamt = sh; amt_var = av; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: every presented output cycle must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset && (busy || done || err)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s unexpected_output: got %b required no activity", cur_test, outv);
                end else begin
                    check(cur_test, outv, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", outv, 11'd0);

        // Release reset and request in the same cycle: accepted at the very next edge
        cur_test = "sll_shamt4_after_reset";
        push_op(3'b010, 1'b0, 1'b0);
        reset = 1'b1; op = 3'b000; shamt = 5'd4; amt_var = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

        run_op("srav_amt31", 3'b101, 5'd0, 5'd31, 3'b100, 1'b1, 1'b0);

        cur_test = "illegal_op110";
        exp_q.push_back(vec(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        op = 3'b110; shamt = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("illegal_idle_after", outv, 11'd0);

        cur_test = "illegal_op111";
        exp_q.push_back(vec(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        op = 3'b111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Start re-asserted during SHIFT and held through DONE must be ignored
        cur_test = "busy_ignore";
        push_op(3'b010, 1'b0, 1'b0);
        @(negedge clk);
        op = 3'b000; shamt = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 3'b001; shamt = 5'd7; amt_var = 5'd7; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-CAPTURE aborts: no done, outputs cleared immediately
        cur_test = "reset_abort";
        exp_q.push_back(vec(3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'b010, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        op = 3'b000; shamt = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        check("capture_before_reset", outv, vec(3'b000, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0));
        reset = 1'b0;
        #1;
        check("reset_clears_now", outv, 11'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_in_reset", outv, 11'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op("srl_after_reset", 3'b001, 5'd5, 5'd0, 3'b011, 1'b0, 1'b0);

        run_op("srl_shamt0", 3'b001, 5'd0, 5'd9, 3'b011, 1'b0, SKIP);
        run_op("sllv_amt5_shamt0", 3'b011, 5'd0, 5'd5, 3'b010, 1'b1, 1'b0);
        run_op("srlv_amt0", 3'b100, 5'd9, 5'd0, 3'b011, 1'b1, SKIP);
        run_op("sra_shamt31", 3'b010, 5'd31, 5'd0, 3'b100, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d expected vectors never presented, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
